// File: rtl/lm07_pkg.sv
`timescale 1ns/1ps
// lm07_pkg: shared constants, FSM state type and helpers for the LM07 emulator.
package lm07_pkg;

    localparam int         FRAME_BITS_DEF  = 16;
    localparam int         MAX_MAG_DEF     = 99;
    localparam logic [7:0] FILL_DEF        = 8'h00;
    localparam int         SYNC_STAGES_DEF = 2;

    // Serial word layout: {sign, magnitude[6:0], fill[7:0]}, MSB first.
    localparam int WORD_BITS = 16;
    localparam int SIGN_BIT  = 15;
    localparam int MAG_HI    = 14;
    localparam int MAG_LO    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } lm07_state_e;

    // Saturate a 7-bit magnitude at the given limit.
    function automatic logic [6:0] sat_mag(input logic [6:0] mag, input logic [6:0] limit);
        return (mag > limit) ? limit : mag;
    endfunction

endpackage

// File: rtl/lm07_emu_slave_if.sv
`timescale 1ns/1ps
// lm07_emu_slave_if: 3-wire read link between sensor-read master and LM07 responder.
interface lm07_emu_slave_if;
    logic CS;      // chip select, active low
    logic SCK;     // serial clock, idles low
    logic SIO;     // serial data, responder to master
    logic SIO_OE;  // board tristate control for SIO

    modport master (output CS, output SCK, input SIO, input SIO_OE);
    modport slave  (input CS, input SCK, output SIO, output SIO_OE);
endinterface

// File: rtl/lm07_sync_edge.sv
`timescale 1ns/1ps
// lm07_sync_edge: multi-flop synchroniser for an asynchronous pin followed by a
// one-cycle rise/fall detector. STAGES must be at least 2.
module lm07_sync_edge #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the pin through the synchroniser chain and keep one cycle of history.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sync_q <= {STAGES{INIT}};
            prev_q <= INIT;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/lm07_emu_slave.sv
`timescale 1ns/1ps
// lm07_emu_slave: LM07 temperature sensor emulator, target end of the CS/SCK/SIO
// read link. Optional macro LM07_PARITY_EN replaces frame bit 0 with even parity
// over bits 15..1; without it bit 0 carries FILL[0].
module lm07_emu_slave
    import lm07_pkg::*;
#(
    parameter int         FRAME_BITS  = FRAME_BITS_DEF,
    parameter int         MAX_MAG     = MAX_MAG_DEF,
    parameter logic [7:0] FILL        = FILL_DEF,
    parameter int         SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             SYSCLK,
    input  logic             RSTN,
    lm07_emu_slave_if.slave  spi,
    input  logic             TEMP_WE,
    input  logic             TEMP_SIGN,
    input  logic [6:0]       TEMP_MAG,
    output logic             BUSY,
    output logic             FRAME_DONE,
    output logic             ABORT,
    output logic             CLAMPED
);

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_SHIFT = 2'(SHIFT);
    localparam logic [1:0] ST_DONE  = 2'(DONE);

    localparam logic [6:0] MAX_MAG_7 = 7'(MAX_MAG);
    localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);

    logic cs_rise, cs_fall, sck_fall, sck_rise_unused;

    lm07_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs_sync (
        .clk_i  (SYSCLK),
        .rstn_i (RSTN),
        .d_i    (spi.CS),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    // The master samples on SCK rise, so only the falling edge matters here.
    lm07_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sck_sync (
        .clk_i  (SYSCLK),
        .rstn_i (RSTN),
        .d_i    (spi.SCK),
        .rise_o (sck_rise_unused),
        .fall_o (sck_fall)
    );

    // Holding register write path: saturate, and fold negative zero to positive.
    logic       sign_h_q, clamped_q;
    logic [6:0] mag_h_q;
    logic [6:0] wr_mag;
    logic       wr_sign;

    assign wr_mag  = sat_mag(TEMP_MAG, MAX_MAG_7);
    assign wr_sign = TEMP_SIGN & (wr_mag != 7'd0);

    // Capture the temperature on a write strobe and track whether it was saturated.
    always_ff @(posedge SYSCLK) begin
        if (!RSTN) begin
            sign_h_q  <= 1'b0;
            mag_h_q   <= 7'd0;
            clamped_q <= 1'b0;
        end else if (TEMP_WE) begin
            sign_h_q  <= wr_sign;
            mag_h_q   <= wr_mag;
            clamped_q <= (TEMP_MAG > MAX_MAG_7);
        end
    end

    // Build the frame word; a write in the snapshot cycle bypasses the holding register.
    logic [WORD_BITS-1:0] frame_word;
    always_comb begin
        frame_word                 = '0;
        frame_word[SIGN_BIT]       = TEMP_WE ? wr_sign : sign_h_q;
        frame_word[MAG_HI:MAG_LO]  = TEMP_WE ? wr_mag  : mag_h_q;
        frame_word[MAG_LO-1:1]     = FILL[7:1];
`ifdef LM07_PARITY_EN
        frame_word[0]              = ^frame_word[WORD_BITS-1:1];
`else
        frame_word[0]              = FILL[0];
`endif
    end

    // Frame FSM: shift_q[MSB] is the SIO pin, cleared whenever no data bit is due.
    logic [1:0]           state_q, state_d;
    logic [WORD_BITS-1:0] shift_q, shift_d;
    logic [4:0]           count_q, count_d;
    logic                 done_q, done_d;
    logic                 abort_q, abort_d;

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        count_d = count_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                shift_d = '0;
                if (cs_fall) begin
                    shift_d = frame_word;
                    count_d = 5'd1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    abort_d = 1'b1;
                    shift_d = '0;
                    count_d = 5'd0;
                    state_d = ST_IDLE;
                end else if (sck_fall) begin
                    if (count_q >= FRAME_CNT) begin
                        shift_d = '0;
                        state_d = ST_DONE;
                    end else begin
                        shift_d = {shift_q[WORD_BITS-2:0], 1'b0};
                        count_d = count_q + 5'd1;
                    end
                end
            end
            ST_DONE: begin
                shift_d = '0;
                if (cs_rise) begin
                    done_d  = 1'b1;
                    count_d = 5'd0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                shift_d = '0;
                count_d = 5'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register the sequencer state and the one-cycle status pulses.
    always_ff @(posedge SYSCLK) begin
        if (!RSTN) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            count_q <= 5'd0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    assign BUSY       = (state_q != ST_IDLE);
    assign spi.SIO_OE = BUSY;
    assign spi.SIO    = shift_q[WORD_BITS-1];
    assign FRAME_DONE = done_q;
    assign ABORT      = abort_q;
    assign CLAMPED    = clamped_q;

endmodule

// File: tb/tb_lm07_emu_slave.sv
`timescale 1ns/1ps
// tb_lm07_emu_slave: directed frames against a word-level model of the LM07 responder.
module tb_lm07_emu_slave;

    localparam int HALF = 25;   // SCK half period in SYSCLK cycles (50 MHz / 1 MHz)
    localparam int SYNC = 2;
    localparam int MAXM = 99;

    logic       SYSCLK = 1'b0;
    logic       RSTN = 1'b0;
    logic       TEMP_WE = 1'b0;
    logic       TEMP_SIGN = 1'b0;
    logic [6:0] TEMP_MAG = 7'd0;
    logic       BUSY, FRAME_DONE, ABORT, CLAMPED;

    lm07_emu_slave_if bus();

    lm07_emu_slave #(
        .FRAME_BITS  (16),
        .MAX_MAG     (MAXM),
        .FILL        (8'h00),
        .SYNC_STAGES (SYNC)
    ) dut (
        .SYSCLK     (SYSCLK),
        .RSTN       (RSTN),
        .spi        (bus.slave),
        .TEMP_WE    (TEMP_WE),
        .TEMP_SIGN  (TEMP_SIGN),
        .TEMP_MAG   (TEMP_MAG),
        .BUSY       (BUSY),
        .FRAME_DONE (FRAME_DONE),
        .ABORT      (ABORT),
        .CLAMPED    (CLAMPED)
    );

    always #10 SYSCLK = ~SYSCLK;

    // Model state: holding register as plain numbers.
    bit          m_sign;
    int          m_mag;
    bit          m_clamped;
    logic [15:0] exp_word;
    logic [15:0] rx;
    int          bit_idx;
    bit          in_frame;
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          abort_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_word();
        logic [15:0] w;
        w = {m_sign, 7'(m_mag), 8'h00};
`ifdef LM07_PARITY_EN
        w[0] = ^w[15:1];
`endif
        return w;
    endfunction

    task automatic model_write(input bit s, input int m);
        m_mag     = (m > MAXM) ? MAXM : m;
        m_clamped = (m > MAXM);
        m_sign    = s && (m_mag != 0);
    endtask

    // Called at a SYSCLK negedge; strobe covers exactly one rising edge.
    task automatic write_temp(input bit s, input int m);
        TEMP_SIGN = s;
        TEMP_MAG  = 7'(m);
        TEMP_WE   = 1'b1;
        @(negedge SYSCLK);
        TEMP_WE   = 1'b0;
        model_write(s, m);
        $display("write sign=%0d mag=%0d", s, m);
    endtask

    // Count cycles on which each pulse is high.
    always @(negedge SYSCLK) begin
        if (FRAME_DONE === 1'b1) done_cnt++;
        if (ABORT === 1'b1) abort_cnt++;
    end

    // Master sampling point: every SCK rise inside a frame must see the model's bit.
    always @(posedge bus.SCK) begin
        logic exp_bit;
        if (in_frame) begin
            exp_bit = (bit_idx < 16) ? exp_word[15-bit_idx] : 1'b0;
            chk($sformatf("bit%0d", bit_idx), 32'({bus.SIO_OE, BUSY, bus.SIO}),
                32'({1'b1, 1'b1, exp_bit}));
            rx = {rx[14:0], bus.SIO};
            bit_idx++;
        end
    end

    task automatic run_frame(input string name, input int nbits, input bit byp, input bit mid,
                             input bit ws, input int wm, input int rst_at, input logic [15:0] lit);
        int d0;
        int a0;
        int waited;
        @(negedge SYSCLK);
        d0 = done_cnt;
        a0 = abort_cnt;
        bus.CS = 1'b0;
        if (byp) begin
            // CS fall is acted on SYNC+1 rising edges after the pin change.
            repeat (SYNC) @(negedge SYSCLK);
            write_temp(ws, wm);
        end
        exp_word = model_word();
        rx       = '0;
        bit_idx  = 0;
        in_frame = 1'b1;
        repeat (HALF) @(negedge SYSCLK);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                in_frame = 1'b0;
                RSTN = 1'b0;
                repeat (2) @(negedge SYSCLK);
                bus.CS = 1'b1;
                m_sign = 1'b0; m_mag = 0; m_clamped = 1'b0;
                repeat (4) @(negedge SYSCLK);
                chk({name, "_rst_sio"}, 32'(bus.SIO), 32'd0);
                chk({name, "_rst_busy"}, 32'(BUSY), 32'd0);
                chk({name, "_rst_oe"}, 32'(bus.SIO_OE), 32'd0);
                RSTN = 1'b1;
                repeat (8) @(negedge SYSCLK);
                chk({name, "_no_abort"}, 32'(abort_cnt - a0), 32'd0);
                chk({name, "_post_busy"}, 32'({BUSY, bus.SIO}), 32'd0);
                $display("frame %s: reset after %0d bits", name, i);
                return;
            end
            bus.SCK = 1'b1;
            repeat (HALF) @(negedge SYSCLK);
            bus.SCK = 1'b0;
            if (mid && i == 3) begin
                write_temp(ws, wm);
                repeat (HALF - 1) @(negedge SYSCLK);
            end else begin
                repeat (HALF) @(negedge SYSCLK);
            end
        end
        bus.CS = 1'b1;
        in_frame = 1'b0;
        if (nbits < 16) begin
            waited = 0;
            while (BUSY === 1'b1 && waited < SYNC + 2) begin
                @(negedge SYSCLK);
                waited++;
            end
            chk({name, "_busy_clear"}, 32'(BUSY), 32'd0);
        end
        repeat (8) @(negedge SYSCLK);
        if (nbits >= 16) begin
            if (nbits == 16) chk({name, "_word"}, 32'(rx), 32'(lit));
            chk({name, "_done"}, 32'(done_cnt - d0), 32'd1);
            chk({name, "_abort"}, 32'(abort_cnt - a0), 32'd0);
        end else begin
            chk({name, "_abort"}, 32'(abort_cnt - a0), 32'd1);
            chk({name, "_done"}, 32'(done_cnt - d0), 32'd0);
        end
        chk({name, "_idle"}, 32'({BUSY, bus.SIO_OE, bus.SIO}), 32'd0);
        $display("frame %s: bits=%0d rx=%04h expected=%04h", name, nbits, rx, exp_word);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] par_lit;
        bus.CS  = 1'b1;
        bus.SCK = 1'b0;
        m_sign = 1'b0; m_mag = 0; m_clamped = 1'b0;
        in_frame = 1'b0;
        repeat (5) @(negedge SYSCLK);
        chk("rst_sio", 32'(bus.SIO), 32'd0);
        chk("rst_oe", 32'(bus.SIO_OE), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_pulses", 32'({FRAME_DONE, ABORT}), 32'd0);
        chk("rst_clamped", 32'(CLAMPED), 32'd0);
        RSTN = 1'b1;
        repeat (4) @(negedge SYSCLK);

        write_temp(1'b0, 25);
        chk("clamped_25", 32'(CLAMPED), 32'(m_clamped));
        run_frame("t25", 16, 0, 0, 0, 0, -1, 16'h1900);

        write_temp(1'b1, 120);
        chk("clamped_120", 32'(CLAMPED), 32'd1);
        run_frame("tm120", 16, 0, 0, 0, 0, -1, 16'hE300);

        run_frame("abort8", 8, 0, 0, 0, 0, -1, 16'h0000);
        run_frame("after_abort", 16, 0, 0, 0, 0, -1, 16'hE300);

        write_temp(1'b0, 99);
        chk("clamped_99", 32'(CLAMPED), 32'd0);
        run_frame("t99", 16, 0, 0, 0, 0, -1, 16'h6300);

        write_temp(1'b0, 30);
        run_frame("mid30", 16, 0, 1, 0, 40, -1, 16'h1E00);
        run_frame("next40", 16, 0, 0, 0, 0, -1, 16'h2800);
        run_frame("extra_sck", 18, 0, 0, 0, 0, -1, 16'h0000);

        write_temp(1'b1, 0);
        run_frame("negzero", 16, 0, 0, 0, 0, -1, 16'h0000);
        write_temp(1'b1, 5);
        run_frame("bypass", 16, 1, 0, 0, 66, -1, 16'h4200);

        write_temp(1'b0, 50);
        run_frame("rst_mid", 16, 0, 0, 0, 0, 5, 16'h0000);
        chk("clamped_after_rst", 32'(CLAMPED), 32'd0);
        run_frame("fresh", 16, 0, 0, 0, 0, -1, 16'h0000);

        write_temp(1'b0, 7);
`ifdef LM07_PARITY_EN
        par_lit = 16'h0701;
`else
        par_lit = 16'h0700;
`endif
        run_frame("t7", 16, 0, 0, 0, 0, -1, par_lit);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lm07_emu_slave.md
Name: lm07_emu_slave

Overview:
SPI responder emulating the LM07 temperature sensor: the target end of the 3-wire read link (CS, SCK, SIO) driven by the sensor-read master. The system writes a sign/magnitude temperature into a holding register. On each CS-low frame the block serialises a 16-bit word MSB-first on SIO. It is used as the sensor model on the FPGA loopback board and as the bench target for the read path.

Parameters:
FRAME_BITS, 16, bits shifted per CS frame
MAX_MAG, 99, magnitude saturation limit (degrees C)
FILL, 8'h00, low byte of frame (status/fill bits)
SYNC_STAGES, 2, flip-flops in CS/SCK synchronisers (min 2)

Ports:
SYSCLK  input  1  responder clock; must be at least 8x SCK frequency
RSTN  input  1  synchronous active-low reset, sampled on rising SYSCLK
CS  input  1  chip select from master, active low, asynchronous to SYSCLK
SCK  input  1  serial clock from master, idles low, asynchronous to SYSCLK
TEMP_WE  input  1  one-cycle write strobe for holding register
TEMP_SIGN  input  1  temperature sign (1 = negative)
TEMP_MAG  input  7  temperature magnitude, binary
SIO  output  1  serial data to master
SIO_OE  output  1  1 while CS is low (board tristate control)
BUSY  output  1  frame in progress
FRAME_DONE  output  1  one-cycle pulse after FRAME_BITS bits are shifted out
ABORT  output  1  one-cycle pulse when CS rises before FRAME_BITS bits are shifted out
CLAMPED  output  1  sticky; set when a write was saturated, cleared on the next unsaturated write

Behaviour:
- Reset (RSTN=0 at rising SYSCLK): SIO=0, SIO_OE=0, BUSY=0, FRAME_DONE=0, ABORT=0, CLAMPED=0, holding register={0,7'd0}, state IDLE, bit counter 0, synchronisers set to CS=1, SCK=0. Reset mid-frame abandons the frame silently; no ABORT pulse is issued.
- Holding register: on TEMP_WE, mag_h = min(TEMP_MAG, MAX_MAG) and sign_h = TEMP_SIGN. CLAMPED is set if TEMP_MAG > MAX_MAG and cleared otherwise. A magnitude of 0 with sign 1 is stored as sign 0 (no negative zero).
- Frame word = {sign_h, mag_h, FILL}, MSB first.
- CS and SCK each pass through a SYNC_STAGES synchroniser, then a one-cycle edge detector. Pin-to-action latency is SYNC_STAGES+1 SYSCLK cycles.
- FSM states:
  - IDLE: SIO=0, SIO_OE=0. On detected CS fall: snapshot the frame word into the shift register, drive bit 15 on SIO, set SIO_OE=1 and BUSY=1, set count=1, go to SHIFT.
  - SHIFT: on each detected SCK fall, shift left and drive the next bit, count+1. When count reaches FRAME_BITS and SCK falls, drive SIO=0 and go to DONE. SCK rising edges are ignored; the master samples SIO on them.
  - DONE: SIO held at 0 for any extra SCK cycles. On detected CS rise: FRAME_DONE=1 for one cycle, BUSY=0, SIO_OE=0, go to IDLE.
  - CS rise detected in SHIFT: ABORT=1 for one cycle, BUSY=0, SIO_OE=0, go to IDLE.
- TEMP_WE in the same cycle as a detected CS fall: the snapshot takes the newly written value (write bypass). TEMP_WE during SHIFT or DONE updates only the holding register; the in-flight frame is unaffected.
- SCK edges detected while CS is high are ignored. A CS fall and an SCK edge detected in the same cycle: the CS fall is processed and the SCK edge is dropped.
- Bit counter is 5 bits wide and saturates at FRAME_BITS; it never wraps.

Optional Feature:
LM07_PARITY_EN
- Defined: frame bit 0 is replaced by even parity over frame bits 15..1, so the total count of ones in the frame is even; FILL[0] is ignored.
- Undefined: bit 0 = FILL[0]. No parity logic is synthesised.

Decomposition:
- Package lm07_pkg: FRAME_BITS default, MAX_MAG, state enum (IDLE, SHIFT, DONE), frame-field index constants (SIGN_BIT=15, MAG_HI=14, MAG_LO=8).
- Sub-module lm07_sync_edge: synchroniser plus rise/fall pulse outputs; instantiated twice, once for CS and once for SCK.

Test Plan:
- Write sign=0, mag=25; 16-clock frame, SCK=1 MHz, SYSCLK=50 MHz -> master samples 16'h1900; FRAME_DONE pulses once after CS rises; CLAMPED=0.
- Write sign=1, mag=120 -> CLAMPED=1; frame reads 16'hE300 (sign 1, mag 99).
- CS rises after 8 SCK rising edges -> ABORT pulses; BUSY=0 within SYNC_STAGES+2 cycles; the next full frame is correct.
- TEMP_WE with mag=40 mid-frame while 30 is being sent -> current frame reads mag 30; the next frame reads 16'h2800.
- RSTN low during bit 5, then a fresh frame -> SIO=0 and BUSY=0 after reset; the fresh frame reads 16'h0000.
- With LM07_PARITY_EN defined: sign=0, mag=7, FILL=0 -> frame 16'h0701 (bit 0 = parity of three ones); without the macro -> 16'h0700.
